// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter among N byte-stream
//   sources. A requester keeps the grant for a whole message, terminated by
//   a byte flagged LAST. Each byte goes through the UART TX_VALID / TX_BUSY
//   handshake. A granted requester that stalls mid-message is dropped by a
//   watchdog.
//
//   Optional feature: define UART_TX_ARB_TAG_EN to prefix every message with
//   a tag byte 8'hF0 | grant_index.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  stall budget in cycles for a granted requester (>= 2)
//
// Ports
//   CLK_I          system clock
//   RESET_N_I      asynchronous active-low reset
//   REQ_VALID_I    [N]   per-requester byte valid
//   REQ_DATA_I     [8N]  byte of requester i on bits [8i+7:8i]
//   REQ_LAST_I     [N]   byte closes the message
//   REQ_READY_O    [N]   byte accepted this cycle (combinational, <= 1 bit set)
//   GRANT_O        [N]   one-hot transmitter owner, 0 when idle
//   ERROR_O              one-cycle pulse when a stalled requester is dropped
//   UART_DATA_O    [8]   byte to the UART TX_DATA input
//   UART_VALID_O         one-cycle strobe to the UART TX_VALID input
//   UART_BUSY_I          UART TX_BUSY
module uart_tx_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           CLK_I,
  input  logic           RESET_N_I,
  input  logic [N-1:0]   REQ_VALID_I,
  input  logic [8*N-1:0] REQ_DATA_I,
  input  logic [N-1:0]   REQ_LAST_I,
  output logic [N-1:0]   REQ_READY_O,
  output logic [N-1:0]   GRANT_O,
  output logic           ERROR_O,
  output logic [7:0]     UART_DATA_O,
  output logic           UART_VALID_O,
  input  logic           UART_BUSY_I
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT);
  // Trip one count early so ERROR_O is high exactly while timer == TIMEOUT-1.
  localparam logic [TW-1:0] TIMER_TRIP = TW'(TIMEOUT - 2);
  localparam logic [IW-1:0] IDX_MAX    = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_FETCH,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [TW-1:0]   timer;
  logic            last_flag;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic [IW-1:0]   next_ptr;

  // Index ptr+off modulo N, valid for off < N.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base,
                                             input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!pick_vld && REQ_VALID_I[rr_index(ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_index(ptr, k);
      end
    end
  end

  // Byte and LAST of the current owner.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gidx == IW'(i)) begin
        sel_data = REQ_DATA_I[8*i +: 8];
        sel_last = REQ_LAST_I[i];
      end
    end
  end

  // Owner plus one, wrapping at N (N need not be a power of two).
  assign next_ptr = (gidx == IDX_MAX) ? '0 : gidx + IW'(1);

  // Only the owner sees READY, and only while its byte is being fetched.
  assign REQ_READY_O = (state == S_FETCH) ? (GRANT_O & REQ_VALID_I) : '0;

  // Arbitration and UART handshake sequencer.
  always_ff @(posedge CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      state        <= S_IDLE;
      ptr          <= '0;
      gidx         <= '0;
      timer        <= '0;
      last_flag    <= 1'b0;
      GRANT_O      <= '0;
      ERROR_O      <= 1'b0;
      UART_VALID_O <= 1'b0;
      UART_DATA_O  <= 8'hFF;
    end else begin
      ERROR_O      <= 1'b0;
      UART_VALID_O <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gidx    <= pick_idx;
            GRANT_O <= N'(1) << pick_idx;
            timer   <= '0;
`ifdef UART_TX_ARB_TAG_EN
            state   <= S_TAG;
`else
            state   <= S_FETCH;
`endif
          end
        end

`ifdef UART_TX_ARB_TAG_EN
        // Tag byte is never the end of a message.
        S_TAG: begin
          UART_DATA_O <= 8'hF0 | 8'(gidx);
          last_flag   <= 1'b0;
          state       <= S_SEND;
        end
`endif

        S_FETCH: begin
          if (REQ_VALID_I[gidx]) begin
            UART_DATA_O <= sel_data;
            last_flag   <= sel_last;
            timer       <= '0;
            state       <= S_SEND;
          end else if (timer == TIMER_TRIP) begin
            timer   <= timer + TW'(1);
            ERROR_O <= 1'b1;
            GRANT_O <= '0;
            ptr     <= next_ptr;
            state   <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_SEND: begin
          if (!UART_BUSY_I) begin
            UART_VALID_O <= 1'b1;
            state        <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          if (UART_BUSY_I) state <= S_WAIT_IDLE;
        end

        S_WAIT_IDLE: begin
          if (!UART_BUSY_I) begin
            if (last_flag) begin
              GRANT_O <= '0;
              ptr     <= next_ptr;
              state   <= S_IDLE;
            end else begin
              timer <= '0;
              state <= S_FETCH;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned BUSY_LEN = 10;

  logic           CLK_I = 1'b0;
  logic           RESET_N_I;
  logic [N-1:0]   REQ_VALID_I;
  logic [8*N-1:0] REQ_DATA_I;
  logic [N-1:0]   REQ_LAST_I;
  logic [N-1:0]   REQ_READY_O;
  logic [N-1:0]   GRANT_O;
  logic           ERROR_O;
  logic [7:0]     UART_DATA_O;
  logic           UART_VALID_O;
  logic           UART_BUSY_I;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I        (CLK_I),
    .RESET_N_I    (RESET_N_I),
    .REQ_VALID_I  (REQ_VALID_I),
    .REQ_DATA_I   (REQ_DATA_I),
    .REQ_LAST_I   (REQ_LAST_I),
    .REQ_READY_O  (REQ_READY_O),
    .GRANT_O      (GRANT_O),
    .ERROR_O      (ERROR_O),
    .UART_DATA_O  (UART_DATA_O),
    .UART_VALID_O (UART_VALID_O),
    .UART_BUSY_I  (UART_BUSY_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [7:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  rq[N][$];
  logic [N-1:0] acc;
  int unsigned busy_cnt;
  logic        busy_hold, busy_block;
  int          cyc, last_valid_cyc, err_cyc, err_cnt, valid_cnt, msg_cnt;
  int          zero_run;
  logic        gap_en;
  int          n_pass, n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: UART/requester models and scoreboard run at the negedge.
  task automatic tick();
    logic [8:0] head;
    exp_t       e;
    @(negedge CLK_I);
    cyc++;
    for (int unsigned i = 0; i < N; i++)
      if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    acc = '0;
    if (UART_VALID_O) begin
      valid_cnt++;
      check("busy_low_before_valid", 32'(UART_BUSY_I), 32'(0));
      check("byte_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("uart_data", 32'(UART_DATA_O), 32'(e.data));
        check("grant_at_send", 32'(GRANT_O), 32'(e.grant));
      end
      busy_cnt = BUSY_LEN;
      last_valid_cyc = cyc;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
    if (ERROR_O) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (GRANT_O == '0) begin
      zero_run++;
    end else begin
      if (gap_en && zero_run != 0) check("handover_gap", 32'(zero_run), 32'(1));
      zero_run = 0;
    end
    UART_BUSY_I = ((busy_cnt != 0) || busy_hold) && !busy_block;
    for (int unsigned i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        head = rq[i][0];
        REQ_VALID_I[i]        = 1'b1;
        REQ_DATA_I[8*i +: 8]  = head[7:0];
        REQ_LAST_I[i]         = head[8];
      end else begin
        REQ_VALID_I[i]        = 1'b0;
        REQ_DATA_I[8*i +: 8]  = 8'h00;
        REQ_LAST_I[i]         = 1'b0;
      end
    end
    #1;
    acc = REQ_READY_O;
    check("ready_onehot0", 32'($onehot0(REQ_READY_O)), 32'(1));
  endtask

  task automatic push_byte(input int unsigned i, input logic [7:0] d,
                           input logic last, input logic first);
    exp_t e;
    e.grant = N'(1) << i;
    if (first) msg_cnt++;
`ifdef UART_TX_ARB_TAG_EN
    if (first) begin
      e.data = 8'hF0 | 8'(i);
      exp_q.push_back(e);
    end
`endif
    e.data = d;
    exp_q.push_back(e);
    rq[i].push_back({last, d});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(REQ_READY_O), 32'(0));
    check({tag, "_grant"}, 32'(GRANT_O), 32'(0));
    check({tag, "_error"}, 32'(ERROR_O), 32'(0));
    check({tag, "_valid"}, 32'(UART_VALID_O), 32'(0));
    check({tag, "_data"}, 32'(UART_DATA_O), 32'(8'hFF));
  endtask

  task automatic wait_done(input string tag);
    int k;
    logic done;
    done = 1'b0;
    for (k = 0; k < 600 && !done; k++) begin
      tick();
      done = (exp_q.size() == 0) && (GRANT_O == '0) && (busy_cnt == 0);
      for (int unsigned i = 0; i < N; i++) if (rq[i].size() != 0) done = 1'b0;
    end
    check({"done_", tag}, 32'(done), 32'(1));
  endtask

  task automatic clear_models();
    for (int unsigned i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    acc = '0;
    busy_cnt = 0;
  endtask

  initial begin
    int t, v0, e0, k;
    n_pass = 0; n_total = 0; cyc = 0; valid_cnt = 0; err_cnt = 0; msg_cnt = 0;
    last_valid_cyc = 0; err_cyc = 0; zero_run = 0; gap_en = 1'b0;
    busy_cnt = 0; busy_hold = 1'b1; busy_block = 1'b0; acc = '0;
    REQ_VALID_I = '0; REQ_DATA_I = '0; REQ_LAST_I = '0;
    UART_BUSY_I = 1'b1;
    RESET_N_I = 1'b1;
    #1 RESET_N_I = 1'b0;

    // Reset state, UART held busy out of reset.
    repeat (3) tick();
    check_reset_vals("rst");
    #2 RESET_N_I = 1'b1;

    // Single message from requester 2 while the UART is still busy.
    push_byte(2, 8'h41, 1'b0, 1'b1);
    push_byte(2, 8'h42, 1'b1, 1'b0);
    repeat (8) tick();
    check("no_valid_while_busy", 32'(valid_cnt), 32'(0));
    check("grant_req2_held", 32'(GRANT_O), 32'(4'b0100));
    busy_hold = 1'b0;
    wait_done("single");

    // Latency with an idle UART.
    push_byte(1, 8'h55, 1'b1, 1'b1);
    tick();
    t = cyc;
    tick();
    check("lat_grant_t1", 32'(GRANT_O), 32'(4'b0010));
`ifndef UART_TX_ARB_TAG_EN
    check("lat_ready_t1", 32'(REQ_READY_O), 32'(4'b0010));
`endif
    tick();
    tick();
    check("lat_valid_t3", 32'(last_valid_cyc - t), 32'(3));
    wait_done("latency");

    // Contention right after reset; requester 0 re-requests at once.
    #2 RESET_N_I = 1'b0;
    tick();
    clear_models();
    #2 RESET_N_I = 1'b1;
    push_byte(0, 8'hA0, 1'b1, 1'b1);
    push_byte(1, 8'hA1, 1'b1, 1'b1);
    push_byte(2, 8'hA2, 1'b1, 1'b1);
    push_byte(3, 8'hA3, 1'b1, 1'b1);
    push_byte(0, 8'hB0, 1'b1, 1'b1);
    for (k = 0; k < 20 && GRANT_O == '0; k++) tick();
    check("contention_first_grant", 32'(GRANT_O), 32'(4'b0001));
    zero_run = 0;
    gap_en = 1'b1;
    wait_done("contention");
    gap_en = 1'b0;

    // Requester 0 asks mid-message of requester 1.
    push_byte(1, 8'hC1, 1'b0, 1'b1);
    push_byte(1, 8'hC2, 1'b0, 1'b0);
    push_byte(1, 8'hC3, 1'b1, 1'b0);
    v0 = valid_cnt;
    for (k = 0; k < 100 && valid_cnt == v0; k++) tick();
    push_byte(0, 8'hD0, 1'b1, 1'b1);
    wait_done("integrity");

    // Timeout: requester 3 stalls after a non-LAST byte.
    e0 = err_cnt;
    push_byte(3, 8'hE3, 1'b0, 1'b1);
    for (k = 0; k < 300 && err_cnt == e0; k++) tick();
    check("timeout_seen", 32'(err_cnt - e0), 32'(1));
    check("timeout_cycle", 32'(err_cyc - last_valid_cyc), 32'(BUSY_LEN + 1 + TIMEOUT - 1));
    check("timeout_grant_cleared", 32'(GRANT_O), 32'(0));
    repeat (3) tick();
    check("error_single_pulse", 32'(err_cnt - e0), 32'(1));
    push_byte(1, 8'hF1, 1'b1, 1'b1);
    push_byte(2, 8'hF2, 1'b1, 1'b1);
    wait_done("after_timeout");

    // Reset while waiting for the UART to report busy.
    busy_block = 1'b1;
    push_byte(2, 8'h61, 1'b0, 1'b1);
    push_byte(2, 8'h62, 1'b1, 1'b0);
    v0 = valid_cnt;
    for (k = 0; k < 100 && valid_cnt == v0; k++) tick();
    tick();
    check("stuck_wait_busy_grant", 32'(GRANT_O), 32'(4'b0100));
    #2 RESET_N_I = 1'b0;
    #1;
    check_reset_vals("async_rst");
    clear_models();
    busy_block = 1'b0;
    busy_hold = 1'b1;
    repeat (2) tick();
    #2 RESET_N_I = 1'b1;
    push_byte(0, 8'h71, 1'b0, 1'b1);
    push_byte(0, 8'h72, 1'b1, 1'b0);
    repeat (6) tick();
    busy_hold = 1'b0;
    wait_done("after_reset");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
